// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART transmitter among NREQ byte requesters
module uart_tx_arb #(
    parameter int          NREQ      = 4,
    parameter int          FRAME_GAP = 2,
    parameter logic [15:0] TIMEOUT   = 16'd4096
) (
    input  logic                fpga_clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     gnt,
    output logic                tx_start,
    output logic [7:0]          tx_data,
    input  logic                tx_busy,
    input  logic                tx_done,
    output logic [2:0]          src_id,
    output logic                arb_busy,
    output logic                err_timeout
);

    typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

    localparam logic [15:0] TO_LAST  = TIMEOUT - 16'd1;
    localparam logic [7:0]  GAP_LAST = (FRAME_GAP == 0) ? 8'd0 : 8'(FRAME_GAP - 1);

    state_t          state, state_n;
    logic [15:0]     wait_cnt, wait_cnt_n;
    logic [7:0]      gap_cnt, gap_cnt_n;
    logic [2:0]      ptr, ptr_n;
    logic [NREQ-1:0] gnt_n;
    logic            tx_start_n, err_n;
    logic [7:0]      tx_data_n;
    logic [2:0]      src_id_n;

    logic            found;
    logic [2:0]      win;
    logic [3:0]      idx, inc;

    always_ff @(posedge fpga_clk) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            ptr         <= '0;
            gnt         <= '0;
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            tx_data     <= 8'h00;
            src_id      <= 3'd0;
        end else begin
            state       <= state_n;
            wait_cnt    <= wait_cnt_n;
            gap_cnt     <= gap_cnt_n;
            ptr         <= ptr_n;
            gnt         <= gnt_n;
            tx_start    <= tx_start_n;
            err_timeout <= err_n;
            tx_data     <= tx_data_n;
            src_id      <= src_id_n;
        end
    end

    // state is itself a flop, so this output is still register-driven
    assign arb_busy = (state != IDLE);

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        gap_cnt_n  = gap_cnt;
        ptr_n      = ptr;
        gnt_n      = '0;
        tx_start_n = 1'b0;
        err_n      = 1'b0;
        tx_data_n  = tx_data;
        src_id_n   = src_id;
        found      = 1'b0;
        win        = '0;
        idx        = '0;

        // Round-robin search: first pending requester at or after the pointer, wrapping
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + 4'(k);
            if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
            for (int j = 0; j < NREQ; j++) begin
                if (!found && req[j] && idx == 4'(j)) begin
                    found = 1'b1;
                    win   = 3'(j);
                end
            end
        end
        inc = {1'b0, win} + 4'd1;

        case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    state_n    = WAIT_DONE;
                    wait_cnt_n = '0;
                    tx_start_n = 1'b1;
                    src_id_n   = win;
                    ptr_n      = (inc == 4'(NREQ)) ? 3'd0 : inc[2:0];
                    for (int j = 0; j < NREQ; j++) begin
                        gnt_n[j] = (win == 3'(j));
                        if (win == 3'(j)) tx_data_n = req_data[8*j +: 8];
                    end
                end
            end
            WAIT_DONE: begin
                // A done arriving on the timeout cycle wins: no error is flagged
                if (tx_done || wait_cnt == TO_LAST) begin
                    err_n     = !tx_done;
                    state_n   = (FRAME_GAP == 0) ? IDLE : GAP;
                    gap_cnt_n = '0;
                end else begin
                    wait_cnt_n = wait_cnt + 16'd1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) state_n = IDLE;
                else gap_cnt_n = gap_cnt + 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb/tb_uart_tx_arb.sv - randomized self-checking bench for uart_tx_arb against a transaction-level model
module tb_uart_tx_arb;
    localparam int          NREQ      = 4;
    localparam int          FRAME_GAP = 2;
    localparam logic [15:0] TIMEOUT   = 16'd16;

    logic               fpga_clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req;
    logic [8*NREQ-1:0]  req_data;
    logic [NREQ-1:0]    gnt;
    logic               tx_start;
    logic [7:0]         tx_data;
    logic               tx_busy;
    logic               tx_done;
    logic [2:0]         src_id;
    logic               arb_busy;
    logic               err_timeout;

    uart_tx_arb #(.NREQ(NREQ), .FRAME_GAP(FRAME_GAP), .TIMEOUT(TIMEOUT)) dut (
        .fpga_clk(fpga_clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done),
        .src_id(src_id), .arb_busy(arb_busy), .err_timeout(err_timeout)
    );

    always #5 fpga_clk = ~fpga_clk;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: frame bookkeeping in absolute cycle numbers
    int          cyc = 0;
    int          m_ptr = 0;
    bit          m_out = 0;
    int          m_start = 0;
    int          m_idle_from = 0;
    logic [NREQ-1:0] e_gnt;
    logic        e_start, e_err, e_busy;
    logic [7:0]  e_data = 8'h00;
    logic [2:0]  e_src = 3'd0;

    // Stand-in transmitter and requester control
    bit x_active = 0;
    int x_start = 0, x_lat = 0;
    int lat_cfg = 10;
    bit force_busy = 0, spurious = 0, hold_req = 0, measure_gap = 0, have_done = 0;
    int last_done = 0, last_start = 0, last_err = -1;
    int grants[$];

    task automatic step();
        bit d_now;
        int w;
        tx_busy = force_busy | x_active;
        tx_done = (x_active && x_lat != 0 && cyc == x_start + x_lat) || (!x_active && spurious);
        d_now = tx_done && x_active;

        e_gnt = '0; e_start = 1'b0; e_err = 1'b0;
        if (rst) begin
            m_ptr = 0; m_out = 0; m_idle_from = cyc + 1;
            e_data = 8'h00; e_src = 3'd0;
        end else if (!m_out && cyc >= m_idle_from) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (w < 0 && req[j]) w = j;
            end
            if (w >= 0 && !tx_busy) begin
                e_gnt = NREQ'(1) << w;
                e_start = 1'b1;
                e_data = req_data[8*w +: 8];
                e_src = 3'(w);
                m_ptr = (w + 1) % NREQ;
                m_out = 1;
                m_start = cyc + 1;
            end
        end else if (m_out) begin
            if (tx_done) begin
                m_out = 0; m_idle_from = cyc + 1 + FRAME_GAP;
            end else if (cyc - m_start == int'(TIMEOUT) - 1) begin
                e_err = 1'b1; m_out = 0; m_idle_from = cyc + 1 + FRAME_GAP;
            end
        end
        e_busy = m_out || (cyc + 1 < m_idle_from);

        @(posedge fpga_clk);
        #1;
        cyc++;
        check("gnt", 32'(gnt), 32'(e_gnt));
        check("tx_start", 32'(tx_start), 32'(e_start));
        check("tx_data", 32'(tx_data), 32'(e_data));
        check("src_id", 32'(src_id), 32'(e_src));
        check("arb_busy", 32'(arb_busy), 32'(e_busy));
        check("err_timeout", 32'(err_timeout), 32'(e_err));

        if (rst || d_now || err_timeout) x_active = 0;
        if (d_now) begin last_done = cyc - 1; have_done = 1; end
        if (err_timeout) last_err = cyc;
        if (tx_start) begin
            // tx_start rises FRAME_GAP+1 edges after the edge that samples tx_done
            if (measure_gap && have_done) check("gap", 32'(cyc - last_done), 32'(FRAME_GAP + 2));
            x_active = 1; x_start = cyc; last_start = cyc;
            x_lat = (lat_cfg >= 0) ? lat_cfg : int'($urandom_range(0, 22));
            grants.push_back(int'(src_id));
        end
        if (!hold_req) req = req & ~gnt;
        spurious = 0;
    endtask

    task automatic run_until_idle();
        int n = 0;
        req = '0;
        while ((arb_busy || x_active) && n < 100) begin step(); n++; end
        check("idle_bound", 32'(arb_busy || x_active), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1; step(); step(); rst = 1'b0;
        have_done = 0;
    endtask

    initial begin
        int n;
        bit saw_err;
        req = '0; req_data = '0; tx_busy = 0; tx_done = 0;
        do_reset();
        check("rst_src", 32'(src_id), 32'd0);

        // Single request from requester 0
        req_data[7:0] = 8'hA5; req = 4'b0001; lat_cfg = 10;
        step();
        check("r0_gnt", 32'(gnt), 32'h1);
        check("r0_data", 32'(tx_data), 32'hA5);
        step();
        check("r0_pulse", 32'(tx_start), 32'd0);
        run_until_idle();

        // Fair rotation with all requesters held
        do_reset();
        grants.delete(); hold_req = 1; measure_gap = 1; req = 4'b1111;
        n = 0;
        while (grants.size() < 5 && n < 300) begin step(); n++; end
        check("rr_count", 32'(grants.size()), 32'd5);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            check("rr_order", 32'(grants[i]), 32'(i % NREQ));
        hold_req = 0; measure_gap = 0;
        run_until_idle();

        // Pointer wraps past the top requester
        req = 4'b0100; lat_cfg = 4; step();
        check("wrap_g2", 32'(src_id), 32'd2);
        run_until_idle();
        req = 4'b0011; step();
        check("wrap_g0", 32'(gnt), 32'h1);
        run_until_idle();

        // Transmitter never finishes
        lat_cfg = 0; req = 4'b0001; step();
        n = 0;
        while (!err_timeout && n < 40) begin step(); n++; end
        check("to_delay", 32'(last_err - last_start), 32'(TIMEOUT));
        run_until_idle();
        lat_cfg = 5; req = 4'b0010; step();
        check("after_to", 32'(gnt), 32'h2);
        run_until_idle();

        // Done on the timeout cycle counts as done
        lat_cfg = 15; req = 4'b0001; last_err = -1;
        for (int i = 0; i < 20; i++) step();
        check("done_wins", 32'(last_err), 32'hFFFFFFFF);
        run_until_idle();

        // Busy transmitter blocks grants
        force_busy = 1; req = 4'b0100; lat_cfg = 3;
        for (int i = 0; i < 5; i++) step();
        check("busy_block", 32'(gnt), 32'h0);
        force_busy = 0; step();
        check("busy_release", 32'(gnt), 32'h4);
        run_until_idle();

        // Reset mid-frame
        lat_cfg = 0; req = 4'b0001; step();
        for (int i = 0; i < 3; i++) step();
        rst = 1'b1; step(); rst = 1'b0;
        check("mid_rst_busy", 32'(arb_busy), 32'd0);
        check("mid_rst_data", 32'(tx_data), 32'h00);
        saw_err = 0;
        for (int i = 0; i < 20; i++) begin step(); saw_err |= err_timeout; end
        check("mid_rst_noerr", 32'(saw_err), 32'd0);
        req = 4'b1000; lat_cfg = 3; step();
        check("mid_rst_regrant", 32'(src_id), 32'd3);
        run_until_idle();

        // Randomized traffic
        lat_cfg = -1;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 7) == 0) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    req[i] = 1'b1;
                end else if (req[i] && $urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
            force_busy = ($urandom_range(0, 9) == 0);
            spurious = !x_active && ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter FRAME_GAP, default 2, SHALL set the idle fpga_clk cycles forced between frames (0..255).
REQ-003 Parameter TIMEOUT, default 16'd4096, SHALL set the fpga_clk cycles allowed from tx_start to tx_done (2..65535).
REQ-004 fpga_clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-006 req  in  NREQ  SHALL carry per-requester byte-pending flags, held high until the matching gnt bit.
REQ-007 req_data  in  8*NREQ  SHALL carry the bytes; requester i uses bits [8i+7:8i], stable while req[i] is high.
REQ-008 gnt  out  NREQ  SHALL be a one-hot, one-cycle acknowledgement that the requester's byte was captured.
REQ-009 tx_start  out  1  SHALL be a one-cycle pulse launching a frame on the transmitter.
REQ-010 tx_data  out  8  SHALL hold the launched byte from tx_start until the next launch.
REQ-011 tx_busy  in  1  SHALL indicate the transmitter is mid-frame.
REQ-012 tx_done  in  1  SHALL be the transmitter's one-cycle end-of-frame pulse.
REQ-013 src_id  out  3  SHALL hold the index of the requester owning the current or last frame.
REQ-014 arb_busy  out  1  SHALL be high in every state except IDLE.
REQ-015 err_timeout  out  1  SHALL be a one-cycle pulse when a frame exceeds TIMEOUT.

Function
REQ-016 The FSM SHALL have states IDLE, WAIT_DONE and GAP; all outputs registered.
REQ-017 IDLE: when req != 0 and tx_busy == 0 in cycle N, the block SHALL drive gnt (winner bit), tx_start, tx_data and src_id in cycle N+1 and enter WAIT_DONE.
REQ-018 IDLE with tx_busy == 1 SHALL not grant, whatever req is.
REQ-019 Arbitration SHALL be round-robin: search begins at (last src_id + 1) mod NREQ and wraps; the first set req bit wins.
REQ-020 A req bit dropped before being sampled in IDLE SHALL not be granted; no request is queued internally.
REQ-021 WAIT_DONE SHALL count cycles in a 16-bit counter cleared on entry; on tx_done go to GAP.
REQ-022 WAIT_DONE SHALL pulse err_timeout and go to GAP when the counter reaches TIMEOUT-1 with no tx_done.
REQ-023 tx_done and timeout in the same cycle SHALL count as done: no err_timeout.
REQ-024 tx_done seen outside WAIT_DONE SHALL be ignored.
REQ-025 GAP SHALL last exactly FRAME_GAP cycles and then enter IDLE; FRAME_GAP == 0 SHALL go from WAIT_DONE straight to IDLE.
REQ-026 gnt and tx_start SHALL never be high for more than one consecutive cycle; at most one frame is outstanding.
REQ-027 The pointer SHALL advance only on a grant; a timed-out frame still advances it.

Reset
REQ-028 rst high SHALL, on the next edge, force IDLE and clear gnt, tx_start, err_timeout and the counters.
REQ-029 Reset SHALL also set tx_data = 8'h00, src_id = 0, and the pointer so requester 0 is searched first.
REQ-030 rst asserted mid-frame SHALL abort without err_timeout, and the first request after release SHALL be granted normally.

Verification
REQ-031 After reset, req=4'b0001, data0=8'hA5, tx_busy=0 -> gnt=4'b0001 and tx_start for one cycle, tx_data=8'hA5, src_id=0.
REQ-032 req=4'b1111 held, tx_done 10 cycles after each tx_start -> grant order 0,1,2,3,0; each tx_start exactly FRAME_GAP+1 cycles after the previous tx_done.
REQ-033 Grant to requester 2, then req=4'b0011 -> requester 0 wins (pointer wraps past 3).
REQ-034 tx_done never arrives, TIMEOUT=16 -> err_timeout exactly 16 cycles after tx_start, then GAP, IDLE, and the next grant proceeds.
REQ-035 tx_busy=1 with req=4'b0100 -> no gnt; tx_busy drops -> gnt=4'b0100 on the following cycle.
REQ-036 rst pulse 3 cycles into WAIT_DONE -> IDLE on the next edge, all outputs at reset values, no err_timeout.
